// File: rtl/trap_unit.sv
// Machine-mode trap controller: owns the M-mode trap CSRs and sequences trap entry, mret, flush and redirect.
// Latency: CSRs update at the accepting edge; flush+redirect the next cycle, flush-only the one after. No backpressure; stall_n gates event sampling.
package trap_pkg;
    typedef struct packed {
        logic        raise;
        logic [3:0]  cause;
        logic [31:0] tval;
    } exception_t;
endpackage

module trap_unit
    import trap_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_sync_n,
    input  logic        stall_n,
    input  exception_t  exception_commit,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
    typedef enum logic [1:0] {IDLE, ENTER, DRAIN} state_t;

    localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic        mstatus_mie, mstatus_mpie, mie_meie, mie_mtie;
    logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, target_q;

    logic [31:0] mstatus_val, mie_val, mip_val, wr_val, trap_target;
    logic        csr_wr, idle_go, ext_pend, tim_pend;
    logic        take_exc, take_irq, take_mret, do_wr;
    logic [3:0]  irq_code;

    always_comb begin
        mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
        mie_val     = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
        mip_val     = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};
        case (csr_addr)
            12'h300: csr_rdata = mstatus_val;
            12'h304: csr_rdata = mie_val;
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            12'h344: csr_rdata = mip_val;
            default: csr_rdata = 32'h0;
        endcase
        case (csr_op)
            2'b01:   wr_val = csr_wdata;
            2'b10:   wr_val = csr_rdata | csr_wdata;
            2'b11:   wr_val = csr_rdata & ~csr_wdata;
            default: wr_val = csr_rdata;
        endcase
    end

    // Set/clear with a zero mask is a pure read and must not count as a write.
    assign csr_wr    = csr_en && (csr_op == 2'b01 || (csr_op != 2'b00 && csr_wdata != 32'h0));
    assign idle_go   = (state_q == IDLE) && stall_n;
    assign ext_pend  = irq_ext & mie_meie;
    assign tim_pend  = irq_timer & mie_mtie;
    assign irq_code  = ext_pend ? 4'd11 : 4'd7;
    assign take_exc  = idle_go && exception_commit.raise;
    assign take_irq  = idle_go && !exception_commit.raise && (ext_pend || tim_pend)
                       && commit_valid && mstatus_mie;
    assign take_mret = idle_go && !exception_commit.raise && !take_irq && mret && commit_valid;
    assign do_wr     = idle_go && !exception_commit.raise && !take_irq && !take_mret && csr_wr;

    assign trap_target = {mtvec_q[31:2], 2'b00}
                       + ((take_irq && mtvec_q[0]) ? {26'b0, irq_code, 2'b00} : 32'h0);

    always_comb begin
        state_d        = IDLE;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        case (state_q)
            IDLE:    state_d = (take_exc || take_irq || take_mret) ? ENTER : IDLE;
            ENTER: begin
                state_d        = DRAIN;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
            end
            DRAIN: begin
                state_d = IDLE;
                flush   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_sync_n) begin
            state_q      <= IDLE;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mie_mtie     <= 1'b0;
            mtvec_q      <= MTVEC_RESET & MTVEC_MASK;
            mscratch_q   <= 32'h0;
            mepc_q       <= 32'h0;
            mcause_q     <= 32'h0;
            mtval_q      <= 32'h0;
            target_q     <= 32'h0;
        end else begin
            state_q <= state_d;
            if (take_exc || take_irq) begin
                mepc_q       <= {commit_pc[31:2], 2'b00};
                mcause_q     <= take_exc ? {28'b0, exception_commit.cause} : {1'b1, 27'b0, irq_code};
                mtval_q      <= take_exc ? exception_commit.tval : 32'h0;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
                target_q     <= trap_target;
            end else if (take_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
                target_q     <= mepc_q;
            end else if (do_wr) begin
                case (csr_addr)
                    12'h300: begin
                        mstatus_mie  <= wr_val[3];
                        mstatus_mpie <= wr_val[7];
                    end
                    12'h304: begin
                        mie_meie <= wr_val[11];
                        mie_mtie <= wr_val[7];
                    end
                    12'h305: mtvec_q    <= wr_val & MTVEC_MASK;
                    12'h340: mscratch_q <= wr_val;
                    12'h341: mepc_q     <= {wr_val[31:2], 2'b00};
                    12'h342: mcause_q   <= wr_val;
                    12'h343: mtval_q    <= wr_val;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trap_unit.sv
// Directed test-plan steps followed by random traffic, all checked against a behavioural model of the trap CSRs.
module tb_trap_unit;
    import trap_pkg::*;

    logic        clk = 1'b0;
    logic        rst_sync_n, stall_n, commit_valid, mret, irq_ext, irq_timer, csr_en;
    exception_t  exc;
    logic [31:0] commit_pc, csr_wdata;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] rdata, rpc, rdata_nv, rpc_nv;
    logic        flush, rv, flush_nv, rv_nv;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: mstatus keeps only MIE/MPIE; busy counts remaining flush cycles.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mtvec_nv, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [31:0] m_tgt, m_tgt_nv;
    int          busy;

    always #5 clk = ~clk;

    trap_unit #(.MTVEC_RESET(32'h0), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst_sync_n(rst_sync_n), .stall_n(stall_n), .exception_commit(exc),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .mret(mret),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .csr_en(csr_en), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(rdata),
        .flush(flush), .redirect_valid(rv), .redirect_pc(rpc));

    trap_unit #(.MTVEC_RESET(32'h0), .VECTORED_EN(1'b0)) dut_nv (
        .clk(clk), .rst_sync_n(rst_sync_n), .stall_n(stall_n), .exception_commit(exc),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .mret(mret),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .csr_en(csr_en), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(rdata_nv),
        .flush(flush_nv), .redirect_valid(rv_nv), .redirect_pc(rpc_nv));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a, input bit nv);
        case (a)
            12'h300: return m_mstatus | 32'h1800;
            12'h304: return m_mie;
            12'h305: return nv ? m_mtvec_nv : m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] apply_op(input logic [31:0] old);
        if (csr_op == 2'b01) return csr_wdata;
        if (csr_op == 2'b10) return old | csr_wdata;
        return old & ~csr_wdata;
    endfunction

    task automatic m_trap(input bit intr, input int code, input logic [31:0] tv);
        m_mepc   = commit_pc & ~32'h3;
        m_mcause = (intr ? 32'h8000_0000 : 32'h0) + code;
        m_mtval  = tv;
        m_mstatus = (m_mstatus[3] ? 32'h80 : 32'h0);
        m_tgt    = (m_mtvec & ~32'h3) + ((intr && m_mtvec[0]) ? 4 * code : 0);
        m_tgt_nv = m_mtvec_nv & ~32'h3;
        busy     = 2;
    endtask

    task automatic model_update();
        bit ext, tim;
        logic [31:0] nv;
        ext = irq_ext && m_mie[11];
        tim = irq_timer && m_mie[7];
        if (!rst_sync_n) begin
            m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mtvec_nv = 0;
            m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; busy = 0;
        end else if (busy > 0) begin
            busy--;
        end else if (stall_n) begin
            if (exc.raise) m_trap(1'b0, int'(exc.cause), exc.tval);
            else if ((ext || tim) && commit_valid && m_mstatus[3]) m_trap(1'b1, ext ? 11 : 7, 32'h0);
            else if (mret && commit_valid) begin
                m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
                m_tgt = m_mepc; m_tgt_nv = m_mepc; busy = 2;
            end else if (csr_en && (csr_op == 2'b01 || (csr_op != 2'b00 && csr_wdata != 0))) begin
                nv = apply_op(m_read(csr_addr, 1'b0));
                case (csr_addr)
                    12'h300: m_mstatus = nv & 32'h88;
                    12'h304: m_mie = nv & 32'h880;
                    12'h305: begin
                        m_mtvec    = nv & 32'hFFFF_FFFD;
                        m_mtvec_nv = apply_op(m_mtvec_nv) & 32'hFFFF_FFFC;
                    end
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~32'h3;
                    12'h342: m_mcause = nv;
                    12'h343: m_mtval = nv;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step();
        #1;
        if (chk_en) begin
            chk("flush", {31'b0, flush}, (busy != 0) ? 32'd1 : 32'd0);
            chk("redirect_valid", {31'b0, rv}, (busy == 2) ? 32'd1 : 32'd0);
            chk("redirect_pc", rpc, (busy == 2) ? m_tgt : 32'h0);
            chk("csr_rdata", rdata, m_read(csr_addr, 1'b0));
            chk("nv_flush", {31'b0, flush_nv}, (busy != 0) ? 32'd1 : 32'd0);
            chk("nv_redirect_valid", {31'b0, rv_nv}, (busy == 2) ? 32'd1 : 32'd0);
            chk("nv_redirect_pc", rpc_nv, (busy == 2) ? m_tgt_nv : 32'h0);
            chk("nv_csr_rdata", rdata_nv, m_read(csr_addr, 1'b1));
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clr();
        rst_sync_n = 1'b1; stall_n = 1'b1; exc = '0; commit_valid = 1'b0; commit_pc = 32'h0;
        mret = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; csr_en = 1'b0; csr_op = 2'b00;
        csr_addr = 12'h0; csr_wdata = 32'h0;
    endtask

    task automatic csr_w(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        clr();
        csr_en = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
        step();
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'h7C0, 12'h301};

    initial begin
        m_tgt = 0; m_tgt_nv = 0;
        @(negedge clk);
        clr(); rst_sync_n = 1'b0;
        step();
        chk_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clr(); csr_addr = addrs[i];
            step();
        end
        clr(); rd("rst_mstatus", 12'h300, 32'h1800);

        // Illegal-instruction trap
        csr_w(12'h305, 2'b01, 32'h200);
        csr_w(12'h300, 2'b01, 32'h8);
        clr(); exc = '{raise: 1'b1, cause: 4'd2, tval: 32'hDEAD_BEEF};
        commit_pc = 32'h100; commit_valid = 1'b1;
        step();
        clr();
        chk("ill_flush_enter", {31'b0, flush}, 32'd1);
        chk("ill_redirect_pc", rpc, 32'h200);
        step();
        chk("ill_flush_drain", {31'b0, flush}, 32'd1);
        chk("ill_rv_drain", {31'b0, rv}, 32'd0);
        step();
        chk("ill_flush_idle", {31'b0, flush}, 32'd0);
        rd("ill_mepc", 12'h341, 32'h100);
        rd("ill_mcause", 12'h342, 32'h2);
        rd("ill_mtval", 12'h343, 32'hDEAD_BEEF);
        rd("ill_mstatus", 12'h300, 32'h1880);

        // MRET
        csr_w(12'h341, 2'b01, 32'h84);
        clr(); mret = 1'b1; commit_valid = 1'b1;
        step();
        clr(); chk("mret_redirect_pc", rpc, 32'h84);
        step(); step();
        rd("mret_mstatus", 12'h300, 32'h1888);

        // Vectored external interrupt
        csr_w(12'h305, 2'b01, 32'h201);
        csr_w(12'h304, 2'b01, 32'h800);
        clr(); irq_ext = 1'b1; commit_valid = 1'b1; commit_pc = 32'h40;
        step();
        clr(); chk("vec_redirect_pc", rpc, 32'h22C);
        step(); step();
        rd("vec_mcause", 12'h342, 32'h8000_000B);
        rd("vec_mepc", 12'h341, 32'h40);

        // Exception + timer + CSR write in the same cycle
        csr_w(12'h304, 2'b01, 32'h880);
        csr_w(12'h300, 2'b10, 32'h8);
        csr_w(12'h340, 2'b01, 32'h11);
        clr(); exc = '{raise: 1'b1, cause: 4'd5, tval: 32'h0}; irq_timer = 1'b1;
        commit_valid = 1'b1; commit_pc = 32'h60;
        csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h55;
        step();
        clr(); irq_timer = 1'b1;
        step(); step();
        rd("sim_mcause", 12'h342, 32'h5);
        rd("sim_mscratch", 12'h340, 32'h11);
        clr(); irq_timer = 1'b1; mret = 1'b1; commit_valid = 1'b1;
        step();
        clr(); irq_timer = 1'b1;
        step(); step();
        irq_timer = 1'b1; commit_valid = 1'b1; commit_pc = 32'h70;
        step();
        clr(); irq_timer = 1'b1;
        chk("sim_timer_redirect", rpc, 32'h21C);
        step(); step();
        rd("sim_timer_mcause", 12'h342, 32'h8000_0007);

        // mtvec without vectoring, unmapped and read-only CSRs
        csr_w(12'h305, 2'b01, 32'hFFFF_FFFF);
        rd("mtvec_rw", 12'h305, 32'hFFFF_FFFD);
        #1 chk("nv_mtvec_rw", rdata_nv, 32'hFFFF_FFFC);
        csr_w(12'h305, 2'b11, 32'hF0);
        csr_addr = 12'h305; #1 chk("nv_mtvec_rc", rdata_nv, 32'hFFFF_FF0C);
        csr_w(12'h305, 2'b10, 32'h3);
        csr_addr = 12'h305; #1 chk("nv_mtvec_rs", rdata_nv, 32'hFFFF_FF0C);
        csr_w(12'h7C0, 2'b01, 32'hFFFF_FFFF);
        rd("unmapped_read", 12'h7C0, 32'h0);
        csr_w(12'h344, 2'b01, 32'hFFFF_FFFF);
        rd("mip_write_ignored", 12'h344, 32'h0);

        // Reset while in ENTER
        clr(); exc = '{raise: 1'b1, cause: 4'd1, tval: 32'h7}; commit_valid = 1'b1;
        step();
        clr(); rst_sync_n = 1'b0;
        step();
        clr();
        chk("rst_enter_flush", {31'b0, flush}, 32'd0);
        chk("rst_enter_rv", {31'b0, rv}, 32'd0);
        chk("rst_enter_rpc", rpc, 32'h0);
        rd("rst_enter_mepc", 12'h341, 32'h0);
        rd("rst_enter_mtvec", 12'h305, 32'h0);
        rd("rst_enter_mstatus", 12'h300, 32'h1800);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            clr();
            rst_sync_n   = ($urandom % 64) != 0;
            stall_n      = ($urandom % 8) != 0;
            exc.raise    = ($urandom % 10) == 0;
            exc.cause    = 4'($urandom);
            exc.tval     = $urandom;
            commit_valid = ($urandom % 4) != 0;
            commit_pc    = $urandom;
            mret         = ($urandom % 8) == 0;
            irq_ext      = ($urandom % 6) == 0;
            irq_timer    = ($urandom % 6) == 0;
            csr_en       = ($urandom % 2) == 0;
            csr_op       = 2'($urandom);
            csr_addr     = addrs[$urandom % 10];
            csr_wdata    = (($urandom % 5) == 0) ? 32'h0 : $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
